// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state type
//   - alignment helper used when a request is accepted
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_t;

  // Halfwords need an even address, words (and the 2'b11 alias) need a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = lane[0];
      default: r = |lane;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   Load path : selects the addressed byte/halfword of the memory word and
//               sign- or zero-extends it to 32 bits (words pass through).
//   Store path: merges the right-aligned store value into the addressed
//               lane(s) of the word read from memory (words replace it all).
// Ports:
//   i_size   access size (lsu_pkg encodings)
//   i_lane   byte lane, Addr[1:0]
//   i_signed sign-extend sub-word loads when 1
//   i_rdata  word read from memory
//   i_sdata  right-aligned store data
//   o_load   extended load result
//   o_merge  merged word for write-back
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = i_rdata >> {i_lane, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = w_shifted[15:0];

    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
      default: o_load = i_rdata;
    endcase

    o_merge = i_rdata;
    case (i_size)
      SZ_BYTE: o_merge[{i_lane, 3'b000} +: 8]       = i_sdata[7:0];
      SZ_HALF: o_merge[{i_lane[1], 4'b0000} +: 16]  = i_sdata[15:0];
      default: o_merge = i_sdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: converts byte-addressed pipeline load/store requests into
// word-indexed accesses on a 32-bit data memory (synchronous write,
// combinational read gated by MemRead). Sub-word stores are done as
// read-modify-write. Busy is high while a request is in flight.
//
// Optional build macro: LSU_BOUNDS_CHECK_EN adds the RangeErr output and
// rejects word indices >= DEPTH without touching memory.
//
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   Req                 request valid (sampled only in IDLE)
//   ReqWrite            1 = store, 0 = load
//   Size                00 byte, 01 halfword, 10/11 word
//   SignedLoad          sign-extend sub-word loads
//   Addr                byte address
//   StoreData           right-aligned store value
//   Busy                state != IDLE
//   Done                one-cycle completion pulse
//   LoadData            extended load result, held until the next load
//   MisalignErr         high with Done for a misaligned request
//   RangeErr            (LSU_BOUNDS_CHECK_EN only) high with Done for index >= DEPTH
//   MemAddr             word index driven to memory
//   MemWriteData        word written to memory
//   MemWriteEnable      memory write strobe
//   MemRead             memory read enable
//   MemReadData         memory read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic             ReqWrite,
  input  logic [1:0]       Size,
  input  logic             SignedLoad,
  input  logic [31:0]      Addr,
  input  logic [31:0]      StoreData,
  output logic             Busy,
  output logic             Done,
  output logic [31:0]      LoadData,
  output logic             MisalignErr,
`ifdef LSU_BOUNDS_CHECK_EN
  output logic             RangeErr,
`endif
  output logic [IDX_W-1:0] MemAddr,
  output logic [31:0]      MemWriteData,
  output logic             MemWriteEnable,
  output logic             MemRead,
  input  logic [31:0]      MemReadData
);

  lsu_state_t       r_state;
  lsu_state_t       w_next;

  logic             r_write;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_lane;
  logic [31:0]      r_sdata;
  logic [IDX_W-1:0] r_mem_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_load;
  logic             r_misalign;

  logic             w_misalign;
  logic             w_range;
  logic             w_is_word;
  logic [31:0]      w_word_idx;
  logic [31:0]      w_load;
  logic [31:0]      w_merge;

  assign w_word_idx = {2'b00, Addr[31:2]};
  assign w_misalign = is_misaligned(Size, Addr[1:0]);
  assign w_is_word  = Size[1];

`ifdef LSU_BOUNDS_CHECK_EN
  logic r_range;
  // Compared on the full 30-bit index so a narrow IDX_W cannot alias an
  // out-of-range address back into range.
  assign w_range  = (w_word_idx >= 32'(DEPTH));
  assign RangeErr = r_range;
`else
  assign w_range  = 1'b0;
`endif

  lsu_lane_align u_align (
    .i_size   (r_size),
    .i_lane   (r_lane),
    .i_signed (r_signed),
    .i_rdata  (MemReadData),
    .i_sdata  (r_sdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    Busy           = (r_state != ST_IDLE);
    Done           = (r_state == ST_RESP);
    MemRead        = (r_state == ST_RD);
    // Gated by Reset so an aborted store never reaches memory.
    MemWriteEnable = (r_state == ST_WR) && !Reset;
    case (r_state)
      ST_IDLE: begin
        if (Req) begin
          if (w_misalign || w_range)       w_next = ST_RESP;
          else if (!ReqWrite || !w_is_word) w_next = ST_RD;
          else                              w_next = ST_WR;
        end
      end
      ST_RD:   w_next = r_write ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_write    <= 1'b0;
      r_size     <= '0;
      r_signed   <= 1'b0;
      r_lane     <= '0;
      r_sdata    <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_load     <= '0;
      r_misalign <= 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
      r_range    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Req) begin
            r_write    <= ReqWrite;
            r_size     <= Size;
            r_signed   <= SignedLoad;
            r_lane     <= Addr[1:0];
            r_sdata    <= StoreData;
            r_mem_addr <= IDX_W'(w_word_idx);
            r_misalign <= w_misalign;
`ifdef LSU_BOUNDS_CHECK_EN
            r_range    <= w_range;
`endif
            // Word stores skip RD, so their write data is taken directly.
            if (ReqWrite && w_is_word) r_wdata <= StoreData;
          end
        end
        ST_RD: begin
          if (r_write) r_wdata <= w_merge;
          else         r_load  <= w_load;
        end
        ST_RESP: begin
          r_misalign <= 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
          r_range    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign LoadData     = r_load;
  assign MisalignErr  = r_misalign;
  assign MemAddr      = r_mem_addr;
  assign MemWriteData = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        ReqWrite;
  logic [1:0]  Size;
  logic        SignedLoad;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic [31:0] LoadData;
  logic        MisalignErr;
`ifdef LSU_BOUNDS_CHECK_EN
  logic        RangeErr;
`endif
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWriteEnable;
  logic        MemRead;
  logic [31:0] MemReadData;

  always #5 Clk = ~Clk;

  load_store_unit #(.DEPTH(64), .IDX_W(32)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Req            (Req),
    .ReqWrite       (ReqWrite),
    .Size           (Size),
    .SignedLoad     (SignedLoad),
    .Addr           (Addr),
    .StoreData      (StoreData),
    .Busy           (Busy),
    .Done           (Done),
    .LoadData       (LoadData),
    .MisalignErr    (MisalignErr),
`ifdef LSU_BOUNDS_CHECK_EN
    .RangeErr       (RangeErr),
`endif
    .MemAddr        (MemAddr),
    .MemWriteData   (MemWriteData),
    .MemWriteEnable (MemWriteEnable),
    .MemRead        (MemRead),
    .MemReadData    (MemReadData)
  );

  // Data memory: synchronous write, read visible while MemRead, otherwise
  // the last value read is held.
  logic [31:0] mem [64];
  logic [31:0] mem_hold;
  logic        init_mem;
  always @(posedge Clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      mem_hold <= '0;
    end else begin
      if (MemWriteEnable) mem[MemAddr[5:0]] <= MemWriteData;
      if (MemRead) mem_hold <= mem[MemAddr[5:0]];
    end
  end
  assign MemReadData = MemRead ? mem[MemAddr[5:0]] : mem_hold;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a byte-addressed memory plus the last load value.
  logic [7:0]  mb [256];
  logic [31:0] model_ld;

  function automatic logic [31:0] model_word(input int i);
    return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
  endfunction

  task automatic model_apply(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic me,
                             output logic we, output logic rd);
    int n;
    logic [31:0] val;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    me = (a % n) != 0;
    if (me) begin
      lat = 1; we = 0; rd = 0;
    end else if (w) begin
      for (int k = 0; k < n; k++) mb[(a + k) & 255] = d[8*k +: 8];
      lat = (n == 4) ? 2 : 3;
      we  = 1;
      rd  = (n != 4);
    end else begin
      val = '0;
      for (int k = 0; k < n; k++) val = val | (32'(mb[(a + k) & 255]) << (8*k));
      if (n < 4 && sg && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      model_ld = val;
      lat = 2; we = 0; rd = 1;
    end
  endtask

  // Issue one request and watch it to completion (bounded).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] ld, output logic me,
                        output logic saw_we, output logic saw_rd, output logic re);
    @(negedge Clk);
    Req = 1'b1; ReqWrite = w; Size = sz; SignedLoad = sg; Addr = a; StoreData = d;
    lat = 0; ld = '0; me = 1'b0; saw_we = 1'b0; saw_rd = 1'b0; re = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (c == 1) Req = 1'b0;
      saw_we = saw_we | MemWriteEnable;
      saw_rd = saw_rd | MemRead;
      if (Done) begin
        lat = c;
        ld  = LoadData;
        me  = MisalignErr;
`ifdef LSU_BOUNDS_CHECK_EN
        re  = RangeErr;
`endif
        break;
      end
    end
    Req = 1'b0;
    @(negedge Clk);
    chk("done_one_cycle", {30'b0, Done, Busy}, 32'd0);
    chk("misalign_cleared", {31'b0, MisalignErr}, 32'd0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic [31:0] ld;
    logic        me;
    logic        we;
    logic        rd;
  } vec_t;

  vec_t tv [14];

  initial begin
    int          lat, mlat;
    logic [31:0] ld;
    logic        me, we, rd, re, mme, mwe, mrd;
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, d;

    tv[0]  = '{1'b0, 2'd0, 1'b0, 32'd20, 32'h0,        2, 32'h0000_0005, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 2'd0, 1'b0, 32'd21, 32'h0000_00AB, 3, 32'h0000_0005, 1'b0, 1'b1, 1'b1};
    tv[2]  = '{1'b0, 2'd2, 1'b0, 32'd20, 32'h0,        2, 32'h0000_AB05, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 2'd1, 1'b0, 32'd26, 32'h0000_8000, 3, 32'h0000_AB05, 1'b0, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 2'd1, 1'b1, 32'd26, 32'h0,        2, 32'hFFFF_8000, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 2'd1, 1'b0, 32'd26, 32'h0,        2, 32'h0000_8000, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 2'd2, 1'b0, 32'd6,  32'h0,        1, 32'h0000_8000, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 2'd2, 1'b0, 32'd12, 32'h1234_5678, 2, 32'h0000_8000, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 2'd0, 1'b1, 32'd21, 32'h0,        2, 32'hFFFF_FFAB, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 2'd1, 1'b0, 32'd13, 32'h0,        1, 32'hFFFF_FFAB, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b0, 2'd3, 1'b0, 32'd12, 32'h0,        2, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b1, 2'd1, 1'b0, 32'd23, 32'h0000_5555, 1, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    tv[12] = '{1'b0, 2'd0, 1'b0, 32'd15, 32'h0,        2, 32'h0000_0012, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b0, 2'd1, 1'b1, 32'd14, 32'h0,        2, 32'h0000_1234, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 64; i++) begin
      mb[4*i]   = 8'(i);
      mb[4*i+1] = 8'h00;
      mb[4*i+2] = 8'h00;
      mb[4*i+3] = 8'h00;
    end
    model_ld = '0;

    // Reset state
    Reset = 1'b1; init_mem = 1'b1;
    Req = 1'b0; ReqWrite = 1'b0; Size = 2'd0; SignedLoad = 1'b0; Addr = '0; StoreData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_flags", {27'b0, Busy, Done, MisalignErr, MemRead, MemWriteEnable}, 32'd0);
    chk("rst_loaddata", LoadData, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwdata", MemWriteData, 32'd0);
    Reset = 1'b0; init_mem = 1'b0;

    // Reset during WR of a word store: memory untouched, no Done.
    @(negedge Clk);
    Req = 1'b1; ReqWrite = 1'b1; Size = 2'd2; Addr = 32'd8; StoreData = 32'hDEAD_BEEF;
    @(negedge Clk);
    Req = 1'b0;
    chk("rstwr_in_wr", {31'b0, MemWriteEnable}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rstwr_we_gated", {31'b0, MemWriteEnable}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("rstwr_idle", {30'b0, Busy, Done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("rstwr_no_done", {30'b0, Busy, Done}, 32'd0);
    end
    chk("rstwr_word2", mem[2], 32'h0000_0002);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      do_req(tv[i].w, tv[i].sz, tv[i].sg, tv[i].a, tv[i].d, lat, ld, me, we, rd, re);
      model_apply(tv[i].w, tv[i].sz, tv[i].sg, tv[i].a, tv[i].d, mlat, mme, mwe, mrd);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("vec%0d_ld", i), ld, tv[i].ld);
      chk($sformatf("vec%0d_flags", i), {29'b0, me, we, rd}, {29'b0, tv[i].me, tv[i].we, tv[i].rd});
    end
    chk("vec_word5", mem[5], 32'h0000_AB05);
    chk("vec_word6", mem[6], 32'h8000_0006);

    // Req pulsed while Busy must be ignored.
    @(negedge Clk);
    Req = 1'b1; ReqWrite = 1'b0; Size = 2'd2; SignedLoad = 1'b0; Addr = 32'd20;
    @(negedge Clk);
    ReqWrite = 1'b1; Addr = 32'd40; StoreData = 32'hCAFE_F00D;
    chk("busy_in_rd", {31'b0, Busy}, 32'd1);
    @(negedge Clk);
    chk("busy_done", {31'b0, Done}, 32'd1);
    chk("busy_ld", LoadData, model_word(5));
    Req = 1'b0;
    model_ld = model_word(5);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("busy_ignored", {30'b0, Busy, MemWriteEnable}, 32'd0);
    end
    chk("busy_word10", mem[10], model_word(10));

`ifdef LSU_BOUNDS_CHECK_EN
    do_req(1'b0, 2'd2, 1'b0, 32'd256, 32'h0, lat, ld, me, we, rd, re);
    chk("range_lat", 32'(lat), 32'd1);
    chk("range_err", {30'b0, re, me}, 32'd2);
    chk("range_ld", ld, model_ld);
    chk("range_noacc", {30'b0, we, rd}, 32'd0);
`endif

    // Randomized requests against the model
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(sz == 2'd0 ? 0 : sz == 2'd1 ? 1 : 3));
      d  = $urandom;
      do_req(w, sz, sg, a, d, lat, ld, me, we, rd, re);
      model_apply(w, sz, sg, a, d, mlat, mme, mwe, mrd);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_ld", i), ld, model_ld);
      chk($sformatf("rnd%0d_flags", i), {29'b0, me, we, rd}, {29'b0, mme, mwe, mrd});
    end

    for (int i = 0; i < 64; i++)
      chk($sformatf("mem%0d", i), mem[i], model_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory (64 x 32-bit, synchronous write, combinational read gated by MemRead). Drives its address, write data, write enable and read enable, and consumes its read data.
- Converts pipeline byte-addressed load/store requests (byte, halfword, word; signed or unsigned loads) into word-indexed memory accesses.
- Sub-word stores are performed as read-modify-write. Busy stalls the pipeline while an access is in flight.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory.
- IDX_W, 32, width of MemAddr (word index driven to the memory).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  request valid; sampled only in IDLE.
- ReqWrite  input  1  1 = store, 0 = load.
- Size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- SignedLoad  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
- Addr  input  32  byte address.
- StoreData  input  32  store value, right-aligned (byte in [7:0], halfword in [15:0]).
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse when the request completes.
- LoadData  output  32  extended load result; valid when Done is high, held until the next load completes.
- MisalignErr  output  1  registered; high with Done for a misaligned request.
- MemAddr  output  IDX_W  word index, Addr[IDX_W+1:2].
- MemWriteData  output  32  merged word to write.
- MemWriteEnable  output  1  memory write strobe.
- MemRead  output  1  memory read enable.
- MemReadData  input  32  memory read data (combinational).

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, port Reset.
- Reset values: state IDLE; Busy, Done, MisalignErr, MemRead and MemWriteEnable = 0; LoadData, MemAddr and MemWriteData = 0.
- Little-endian byte lanes: lane = Addr[1:0]; byte n occupies bits [8n+7:8n].
- Alignment: halfword needs Addr[0]=0; word needs Addr[1:0]=00.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: if Req, latch the request into internal registers.
  - Misaligned -> RESP with MisalignErr=1; no memory access occurs.
  - Load, or sub-word store -> RD.
  - Word store -> WR.
- RD: MemRead=1 and MemAddr=index for the whole cycle.
  - Load: extract the lane, extend it, register into LoadData -> RESP.
  - Sub-word store: capture MemReadData, merge StoreData into the addressed lane(s), register into MemWriteData -> WR.
- WR: MemWriteEnable = (state==WR) && !Reset, one cycle; memory writes at the end of WR -> RESP.
- RESP: Done=1 for one cycle -> IDLE. MisalignErr is cleared on leaving RESP.
- Latency from Req to Done: load 2 cycles; word store 2 cycles; sub-word store 3 cycles; misaligned 1 cycle.
- Next request accepted the cycle after Done (first cycle back in IDLE).
- Req while Busy is ignored; the pipeline must hold Req until Busy=0.
- MemRead stays high through all of RD, because the memory output holds its last value when MemRead=0.
- Reset mid-operation: returns to IDLE at the edge. A write in progress in WR is suppressed (no memory write on the reset cycle). Done is not pulsed for the aborted request.
- A store does not change LoadData.

Optional Feature:
- LSU_BOUNDS_CHECK_EN defined:
  - A word index >= DEPTH goes IDLE -> RESP with RangeErr=1 (extra 1-bit output, registered, same timing as MisalignErr).
  - No memory access occurs; loads leave LoadData unchanged.
- Undefined: no RangeErr port; the index is passed through unchecked.

Decomposition:
- Package lsu_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding.
- Sub-module lsu_lane_align (combinational):
  - Lane extract plus sign/zero extension for loads.
  - Byte/halfword merge for stores.
  - Shared by RD-state logic; kept separate for unit testing.

Test Plan:
- Memory initialised with word i = i. Load byte, unsigned, Addr=20 -> Done 2 cycles after Req, LoadData=0x00000005, no write strobe.
- Store byte 0xAB at Addr=21 -> RD, WR, RESP; word 5 = 0x0000AB05. Then a word load at Addr=20 returns 0x0000AB05.
- Store halfword 0x8000 at Addr=26 -> word 6 = 0x80000006. Then:
  - Signed halfword load at 26 -> 0xFFFF8000.
  - Unsigned halfword load at 26 -> 0x00008000.
- Word load at Addr=6 -> Done 1 cycle after Req, MisalignErr=1, MemRead and MemWriteEnable never asserted.
- Reset asserted during WR of a word store of 0xDEADBEEF to Addr=8 -> word 2 remains 0x00000002, state IDLE, Done not pulsed.
- LSU_BOUNDS_CHECK_EN defined: word load at Addr=256 (index 64) -> RangeErr=1, LoadData unchanged. Req pulses while Busy -> ignored.
